// File: rtl/wb_pipe.sv
// KLP32 writeback stage: registers one retiring instruction, aligns load data, drives rf write + forwarding.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [31:0]           i_inst,
    input  logic                  i_reg_wr_en,
    input  logic [1:0]            i_wb_sel,
    input  logic [XLEN-1:0]       i_alu_result,
    input  logic [XLEN-1:0]       i_load_data,
    input  logic [XLEN-1:0]       i_pc,
    input  logic [XLEN-1:0]       i_imm,
    output logic                  o_writeback_reg_wr_en,
    output logic [XLEN-1:0]       o_writeback_wb_mux_result,
    output logic [REG_ADDR_W-1:0] o_writeback_write_addr,
    output logic                  o_fwd_valid,
    output logic                  o_misalign,
    output logic [CNT_W-1:0]      o_retire_count
);

    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;
    logic [1:0]            addr;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       ld_ext;
    logic [XLEN-1:0]       result;
    logic                  mis;

    logic                  valid_q;
    logic                  wr_en_q;
    logic                  mis_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [XLEN-1:0]       data_q;
    logic                  wr;

    logic                  unused_inst_bits;

    assign rd     = i_inst[REG_ADDR_W+6:7];
    assign funct3 = i_inst[14:12];
    assign addr   = i_alu_result[1:0];
    assign unused_inst_bits = ^{i_inst[31:15], i_inst[6:0]};

    always_comb begin
        ld_byte = i_load_data[7:0];
        case (addr)
            2'd0: ld_byte = i_load_data[7:0];
            2'd1: ld_byte = i_load_data[15:8];
            2'd2: ld_byte = i_load_data[23:16];
            2'd3: ld_byte = i_load_data[31:24];
            default: ld_byte = i_load_data[7:0];
        endcase
        ld_half = addr[1] ? i_load_data[31:16] : i_load_data[15:0];
        case (funct3)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = i_load_data;
        endcase
    end

    always_comb begin
        result = i_alu_result;
        case (i_wb_sel)
            2'd0: result = i_alu_result;
            2'd1: result = ld_ext;
            2'd2: result = i_pc + {{(XLEN-3){1'b0}}, 3'd4};
            2'd3: result = i_imm;
            default: result = i_alu_result;
        endcase
    end

    // Misalignment only matters for loads; other sources ignore the low address bits.
    assign mis = (i_wb_sel == 2'd1) &&
                 ((((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0]) ||
                  ((funct3 == 3'b010) && (addr != 2'd0)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            wr_en_q <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            if (i_flush)
                valid_q <= 1'b0;
            else if (!i_stall)
                valid_q <= i_valid;
            if (!i_stall) begin
                wr_en_q <= i_reg_wr_en;
                mis_q   <= mis;
                rd_q    <= rd;
                data_q  <= result;
            end
        end
    end

    assign wr = valid_q & wr_en_q & (rd_q != '0) & ~mis_q;

    assign o_ready                   = ~i_stall;
    assign o_writeback_reg_wr_en     = wr;
    assign o_fwd_valid               = wr;
    assign o_writeback_wb_mux_result = data_q;
    assign o_writeback_write_addr    = rd_q;
    assign o_misalign                = valid_q & mis_q & ~i_stall;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Counts every instruction that leaves, including suppressed writes; wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            cnt_q <= '0;
        else if (valid_q && !i_stall)
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign o_retire_count = cnt_q;
`else
    assign o_retire_count = '0;
`endif

endmodule
